// File: rtl/arbitro_pwm_discreto_pkg.sv
// pwm_arb_pkg: FSM states, width codes and next-owner search shared by the PWM arbiter.
package pwm_arb_pkg;
   typedef enum logic {IDLE, DONO} estado_t;
   localparam logic [1:0] LARG_00 = 2'b00;
   localparam logic [1:0] LARG_01 = 2'b01;
   localparam logic [1:0] LARG_10 = 2'b10;
   localparam logic [1:0] LARG_11 = 2'b11;
   // One-hot of the first request at or after ptr, cyclic over n lanes; 0 when none.
   function automatic logic [7:0] prox_grant(input logic [7:0] req, input int ptr, input int n);
      logic [7:0] g;
      int idx;
      g = '0;
      for (int i = n - 1; i >= 0; i--) begin
         idx = (ptr + i) % n;
         if (req[idx]) begin
            g = '0;
            g[idx] = 1'b1;
         end
      end
      return g;
   endfunction
endpackage

// File: rtl/arbitro_pwm_discreto_contador.sv
// contador_periodo_pwm: PWM-aligned period counter; ae marks the edge at count CONF_PERIODO-2.
module contador_periodo_pwm #(
   parameter int CONF_PERIODO = 1250
) (
   input  logic clock,
   input  logic reset,
   output logic ae
);
   localparam int CW = $clog2(CONF_PERIODO);
   logic [CW-1:0] contagem;
   always_ff @(posedge clock or posedge reset)
      if (reset) contagem <= '0;
      else contagem <= (contagem == CW'(CONF_PERIODO - 1)) ? '0 : contagem + 1'b1;
   assign ae = contagem == CW'(CONF_PERIODO - 2);
endmodule

// File: rtl/arbitro_pwm_discreto.sv
// arbitro_pwm_discreto: shares one PWM width input among N_REQ requesters, switching one clock before the period wrap.
// ARB_PRIORIDADE_FIXA_EN selects fixed lowest-index priority instead of round-robin with QUANTUM.
module arbitro_pwm_discreto
   import pwm_arb_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CONF_PERIODO = 1250,
   parameter int QUANTUM      = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [2*N_REQ-1:0] req_largura,
   output logic [1:0]         largura,
   output logic [N_REQ-1:0]   grant,
   output logic               ativo,
   output logic               troca
);
   estado_t          estado;
   logic             ae;
   logic [N_REQ-1:0] g_prox;
   logic [1:0]       larg_prox;
   contador_periodo_pwm #(.CONF_PERIODO(CONF_PERIODO)) u_contador (
      .clock(clock),
      .reset(reset),
      .ae(ae)
   );
`ifdef ARB_PRIORIDADE_FIXA_EN
   always_comb begin
      g_prox = N_REQ'(prox_grant(8'(req), 0, N_REQ));
      larg_prox = LARG_00;
      for (int i = 0; i < N_REQ; i++)
         if (g_prox[i]) larg_prox = req_largura[2*i +: 2];
   end
`else
   localparam int IW = $clog2(N_REQ);
   localparam int HW = $clog2(QUANTUM + 1);
   logic [IW-1:0] ptr, dono, dono_prox, k_prox;
   logic [HW-1:0] hold;
   logic          rot;
   always_comb begin
      k_prox = (dono == IW'(N_REQ - 1)) ? '0 : dono + 1'b1;
      rot = !req[dono] || (hold == HW'(QUANTUM) && |(req & ~grant));
      g_prox = (estado == IDLE) ? N_REQ'(prox_grant(8'(req), int'(ptr), N_REQ)) :
               rot ? N_REQ'(prox_grant(8'(req), int'(k_prox), N_REQ)) : grant;
      larg_prox = LARG_00;
      dono_prox = dono;
      for (int i = 0; i < N_REQ; i++)
         if (g_prox[i]) begin
            larg_prox = req_largura[2*i +: 2];
            dono_prox = IW'(i);
         end
   end
`endif
   assign ativo = estado == DONO;
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         estado  <= IDLE;
         grant   <= '0;
         largura <= LARG_00;
         troca   <= 1'b0;
`ifndef ARB_PRIORIDADE_FIXA_EN
         ptr     <= '0;
         dono    <= '0;
         hold    <= '0;
`endif
      end else begin
         troca <= 1'b0;
         if (ae) begin
            estado  <= |g_prox ? DONO : IDLE;
            grant   <= g_prox;
            largura <= larg_prox;
            troca   <= g_prox != grant;
`ifndef ARB_PRIORIDADE_FIXA_EN
            dono    <= dono_prox;
            hold    <= (g_prox != grant) ? HW'(1) : (hold == HW'(QUANTUM)) ? hold : hold + 1'b1;
            if (estado == DONO && g_prox != grant) ptr <= k_prox;
`endif
         end
      end
endmodule

// File: tb/tb_arbitro_pwm_discreto.sv
// tb_arbitro_pwm_discreto: scoreboard bench; stimulus pushes the expected owner state per period, monitor checks it after each AE.
module tb_arbitro_pwm_discreto;
   localparam int P = 1250;
   typedef struct packed {
      logic [3:0] g;
      logic [1:0] l;
      logic       a;
      logic       t;
   } esp_t;
   logic       clock = 1'b0, reset = 1'b1;
   logic [3:0] req = '0;
   logic [7:0] req_largura = '0;
   logic [1:0] largura;
   logic [3:0] grant;
   logic       ativo, troca;
   int         cnt_ref = 0;
   int         checks = 0, failures = 0;
   esp_t       fila[$];

   arbitro_pwm_discreto #(.N_REQ(4), .CONF_PERIODO(P), .QUANTUM(4)) dut (
      .clock(clock),
      .reset(reset),
      .req(req),
      .req_largura(req_largura),
      .largura(largura),
      .grant(grant),
      .ativo(ativo),
      .troca(troca)
   );

   always #5 clock = ~clock;

   always @(posedge clock or posedge reset)
      if (reset) cnt_ref <= 0;
      else cnt_ref <= (cnt_ref == P - 1) ? 0 : cnt_ref + 1;

   always @(negedge clock) begin
      esp_t e, got;
      if (!reset) begin
         got = {grant, largura, ativo, troca};
         if (cnt_ref == P - 1 && fila.size() > 0) begin
            e = fila.pop_front();
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL ae_saida: got grant=%b largura=%b ativo=%b troca=%b, want grant=%b largura=%b ativo=%b troca=%b",
                        grant, largura, ativo, troca, e.g, e.l, e.a, e.t);
            end
         end else if (cnt_ref != P - 1 && troca) begin
            checks++;
            failures++;
            $display("FAIL troca_fora_ae: troca=1 at cnt=%0d, want 0", cnt_ref);
         end
      end
   end

   task automatic chk(input string nome, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b want %b", nome, got, want);
      end
   endtask

   task automatic ate(input int c);
      for (int n = 0; n < 2 * P; n++) begin
         @(negedge clock);
         if (cnt_ref == c) return;
      end
      checks++;
      failures++;
      $display("FAIL timeout_ate: cnt %0d not reached, got cnt=%0d", c, cnt_ref);
   endtask

   task automatic periodo(input logic [3:0] r, input logic [7:0] rl, input logic [3:0] eg,
                          input logic [1:0] el, input logic et);
      ate(600);
      req = r;
      req_largura = rl;
      fila.push_back({eg, el, |eg, et});
   endtask

   logic [3:0] rot_g[11] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                             4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
   logic       rot_t[11] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

   initial begin
      repeat (3) @(negedge clock);
      chk("reset_grant", 8'(grant), 8'h00);
      chk("reset_largura", 8'(largura), 8'h00);
      chk("reset_ativo_troca", 8'({ativo, troca}), 8'h00);
      reset = 1'b0;
      periodo(4'b0001, 8'h02, 4'b0001, 2'b10, 1'b1);
      periodo(4'b0001, 8'h02, 4'b0001, 2'b10, 1'b0);
      for (int i = 0; i < 11; i++)
         periodo(4'b0011, 8'h06, rot_g[i], rot_g[i][0] ? 2'b10 : 2'b01, rot_t[i]);
      periodo(4'b0000, 8'h06, 4'b0000, 2'b00, 1'b1);
      ate(610);
      chk("solta_largura_estavel", 8'(largura), 8'h01);
      chk("solta_grant_estavel", 8'(grant), 8'h02);
      periodo(4'b0000, 8'h00, 4'b0000, 2'b00, 1'b0);
      periodo(4'b0001, 8'h01, 4'b0001, 2'b01, 1'b1);
      periodo(4'b0001, 8'h03, 4'b0001, 2'b11, 1'b0);
      ate(610);
      chk("codigo_so_no_ae", 8'(largura), 8'h01);
      ate(600);
      reset = 1'b1;
      #1;
      chk("reset_async_grant", 8'(grant), 8'h00);
      chk("reset_async_largura", 8'(largura), 8'h00);
      chk("reset_async_ativo", 8'(ativo), 8'h00);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      periodo(4'b0001, 8'h03, 4'b0001, 2'b11, 1'b1);
      ate(1248);
      chk("pre_primeiro_ae_ativo", 8'(ativo), 8'h00);
      for (int n = 0; n < 2 * P && fila.size() > 0; n++) @(negedge clock);
      if (fila.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL fila_pendente: got %0d entries left, want 0", fila.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
